// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU together
// with the architectural HI/LO register pair, living in the EXE stage.
//
// One quotient bit is produced per cycle on unsigned magnitudes. The signs are
// applied in a final DONE cycle, and that cycle also writes HI (remainder) and
// LO (quotient). While the divide runs, exe_busy asks the hazard unit to stall
// the pipeline. HI/LO also take MTHI/MTLO writes, and they feed MFHI/MFLO reads
// straight from the registers.
//
// Optional build macro:
//   DIV_FASTZERO_EN - a zero divisor skips the iterative phase and goes straight
//                     to the writeback cycle. This build gives the same results
//                     as the iterative path.

module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  input  logic             div_cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             exe_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] hi_rdata,
  output logic [WIDTH-1:0] lo_rdata
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control state
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;

  // Divider datapath: partial remainder, quotient and divisor magnitudes.
  // On load, quo_q holds the dividend magnitude. Dividend bits shift out of
  // the top of quo_q while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  // Architectural HI/LO
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand conditioning
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             start_ok;
`ifdef DIV_FASTZERO_EN
  logic             divisor_zero;
`endif

  // Single restoring step
  logic [WIDTH:0]   step_shift;
  logic [WIDTH:0]   step_diff;
  logic             step_fits;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Sign-corrected results
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  logic             busy_raw;

  // Take magnitudes of the operands. DIVU treats both operands as plain unsigned values.
  always_comb begin
    a_neg    = div_signed & div_dividend[WIDTH-1];
    b_neg    = div_signed & div_divisor[WIDTH-1];
    a_abs    = a_neg ? (-div_dividend) : div_dividend;
    b_abs    = b_neg ? (-div_divisor) : div_divisor;
    start_ok = div_start & ~div_cancel;
`ifdef DIV_FASTZERO_EN
    divisor_zero = (div_divisor == '0);
`endif
  end

  // One restoring iteration. The borrow out of the (WIDTH+1)-bit subtract gives the
  // rem >= divisor compare, so no separate comparator is needed.
  always_comb begin
    step_shift = {rem_q, quo_q[WIDTH-1]};
    step_diff  = step_shift - {1'b0, dvs_q};
    step_fits  = ~step_diff[WIDTH];
    step_rem   = step_fits ? step_diff[WIDTH-1:0] : step_shift[WIDTH-1:0];
    step_quo   = {quo_q[WIDTH-2:0], step_fits};
  end

  // Apply the quotient and remainder signs for the writeback cycle. The remainder takes the dividend's sign.
  always_comb begin
    quo_fixed = q_neg_q ? (-quo_q) : quo_q;
    rem_fixed = r_neg_q ? (-rem_q) : rem_q;
  end

  // FSM next state, datapath load/step and control outputs.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    busy_raw = 1'b0;
    div_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          busy_raw = 1'b1;
          dvs_d    = b_abs;
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          rem_d    = '0;
          quo_d    = a_abs;
          count_d  = CW'(WIDTH - 1);
          state_d  = RUN;
`ifdef DIV_FASTZERO_EN
          if (divisor_zero) begin
            quo_d   = '1;
            rem_d   = a_abs;
            state_d = DONE;
          end
`endif
        end
      end

      RUN: begin
        busy_raw = 1'b1;
        if (div_cancel) begin
          state_d = IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q - 1'b1;
          if (count_q == '0) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        div_done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The stall request must also drop while resetn is asserted. It is forced low during reset even if EXE still shows a DIV.
  always_comb begin
    exe_busy = resetn & busy_raw;
  end

  // HI/LO update: the divide writeback has priority, and MTHI/MTLO is accepted only when the unit is idle and no divide is starting.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == DONE) begin
      hi_d = rem_fixed;
      lo_d = quo_fixed;
    end else if ((state_q == IDLE) && !start_ok) begin
      if (hi_we) begin
        hi_d = hilo_wdata;
      end
      if (lo_we) begin
        lo_d = hilo_wdata;
      end
    end
  end

  // State, datapath and HI/LO registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: directed checks of the HI/LO divider. Every expected value is worked out by hand.
// Inputs are driven at the falling clock edge, and outputs are sampled 1 ns later.

module tb_hilo_div_unit;

  logic        clk;
  logic        resetn;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  logic        exe_busy;
  logic        div_done;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DIV_FASTZERO_EN
  localparam int ZERO_BUSY = 1;
`else
  localparam int ZERO_BUSY = 33;
`endif

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_cancel   (div_cancel),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .hilo_wdata   (hilo_wdata),
    .exe_busy     (exe_busy),
    .div_done     (div_done),
    .hi_rdata     (hi_rdata),
    .lo_rdata     (lo_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a divide and hold div_start until the div_done cycle. The task counts busy cycles and done pulses, and it gives up after 80 cycles.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    div_signed   = sgn;
    div_dividend = a;
    div_divisor  = b;
    div_start    = 1'b1;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (exe_busy) busy_n++;
      if (div_done) begin
        done_n++;
        break;
      end
      @(negedge clk);
    end
  endtask

  // The DIV leaves EXE in the cycle after writeback. Any extra done pulse seen then is also counted.
  task automatic end_div(output int extra_done);
    @(negedge clk);
    div_start = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    #1;
    extra_done = div_done ? 1 : 0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    div_start = 1'b0; div_signed = 1'b0; div_dividend = '0; div_divisor = '0;
    div_cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    #2;
    n_cmp++; if (exe_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", exe_busy); end
    n_cmp++; if (div_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b expected 0", div_done); end
    n_cmp++; if (hi_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_hi: got %h expected 0", hi_rdata); end
    n_cmp++; if (lo_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_lo: got %h expected 0", lo_rdata); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_divu;
    logic [31:0] va[3], vb[3], elo[3], ehi[3];
    int busy_n, done_n, extra;
    va[0] = 32'd100;       vb[0] = 32'd7;  elo[0] = 32'd14;        ehi[0] = 32'd2;
    va[1] = 32'hFFFFFFFF;  vb[1] = 32'd16; elo[1] = 32'h0FFFFFFF;  ehi[1] = 32'd15;
    va[2] = 32'd5;         vb[2] = 32'd9;  elo[2] = 32'd0;         ehi[2] = 32'd5;
    for (int i = 0; i < 3; i++) begin
      run_div(1'b0, va[i], vb[i], busy_n, done_n);
      end_div(extra);
      n_cmp++; if (busy_n !== 33) begin n_bad++; $display("[TB] FAIL divu%0d_busy: got %0d expected 33", i, busy_n); end
      n_cmp++; if (done_n + extra !== 1) begin n_bad++; $display("[TB] FAIL divu%0d_done: got %0d expected 1", i, done_n + extra); end
      n_cmp++; if (lo_rdata !== elo[i]) begin n_bad++; $display("[TB] FAIL divu%0d_lo: got %h expected %h", i, lo_rdata, elo[i]); end
      n_cmp++; if (hi_rdata !== ehi[i]) begin n_bad++; $display("[TB] FAIL divu%0d_hi: got %h expected %h", i, hi_rdata, ehi[i]); end
    end
  endtask

  task automatic test_div_signed;
    logic [31:0] va[4], vb[4], elo[4], ehi[4];
    int busy_n, done_n, extra;
    va[0] = 32'hFFFFFF9C; vb[0] = 32'd7;        elo[0] = 32'hFFFFFFF2; ehi[0] = 32'hFFFFFFFE;
    va[1] = 32'd100;      vb[1] = 32'hFFFFFFF9; elo[1] = 32'hFFFFFFF2; ehi[1] = 32'd2;
    va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; elo[2] = 32'h80000000; ehi[2] = 32'd0;
    va[3] = 32'hFFFFFF9C; vb[3] = 32'hFFFFFFF9; elo[3] = 32'd14;       ehi[3] = 32'hFFFFFFFE;
    for (int i = 0; i < 4; i++) begin
      run_div(1'b1, va[i], vb[i], busy_n, done_n);
      end_div(extra);
      n_cmp++; if (busy_n !== 33) begin n_bad++; $display("[TB] FAIL div%0d_busy: got %0d expected 33", i, busy_n); end
      n_cmp++; if (done_n + extra !== 1) begin n_bad++; $display("[TB] FAIL div%0d_done: got %0d expected 1", i, done_n + extra); end
      n_cmp++; if (lo_rdata !== elo[i]) begin n_bad++; $display("[TB] FAIL div%0d_lo: got %h expected %h", i, lo_rdata, elo[i]); end
      n_cmp++; if (hi_rdata !== ehi[i]) begin n_bad++; $display("[TB] FAIL div%0d_hi: got %h expected %h", i, hi_rdata, ehi[i]); end
    end
  endtask

  task automatic test_divzero;
    logic [31:0] va[2], elo[2], ehi[2];
    int busy_n, done_n, extra;
    va[0] = 32'd7;        elo[0] = 32'hFFFFFFFF; ehi[0] = 32'd7;
    va[1] = 32'hFFFFFFF9; elo[1] = 32'd1;        ehi[1] = 32'hFFFFFFF9;
    for (int i = 0; i < 2; i++) begin
      run_div(1'b1, va[i], 32'd0, busy_n, done_n);
      end_div(extra);
      n_cmp++; if (busy_n !== ZERO_BUSY) begin n_bad++; $display("[TB] FAIL divzero%0d_busy: got %0d expected %0d", i, busy_n, ZERO_BUSY); end
      n_cmp++; if (done_n + extra !== 1) begin n_bad++; $display("[TB] FAIL divzero%0d_done: got %0d expected 1", i, done_n + extra); end
      n_cmp++; if (lo_rdata !== elo[i]) begin n_bad++; $display("[TB] FAIL divzero%0d_lo: got %h expected %h", i, lo_rdata, elo[i]); end
      n_cmp++; if (hi_rdata !== ehi[i]) begin n_bad++; $display("[TB] FAIL divzero%0d_hi: got %h expected %h", i, hi_rdata, ehi[i]); end
    end
  endtask

  // HI/LO start this test at FFFFFFF9 / 1, left there by the last divide-by-zero vector.
  task automatic test_cancel;
    int done_n;
    done_n = 0;
    @(negedge clk);
    div_signed = 1'b0; div_dividend = 32'd100; div_divisor = 32'd7; div_start = 1'b1;
    #1;
    n_cmp++; if (exe_busy !== 1'b1) begin n_bad++; $display("[TB] FAIL cancel_start_busy: got %b expected 1", exe_busy); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (div_done) done_n++;
    end
    div_cancel = 1'b1;
    #1;
    if (div_done) done_n++;
    @(negedge clk);
    div_cancel = 1'b0;
    div_start  = 1'b0;
    #1;
    n_cmp++; if (exe_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL cancel_busy: got %b expected 0", exe_busy); end
    for (int i = 0; i < 40; i++) begin
      if (div_done) done_n++;
      @(negedge clk);
      #1;
    end
    n_cmp++; if (done_n !== 0) begin n_bad++; $display("[TB] FAIL cancel_done: got %0d expected 0", done_n); end
    n_cmp++; if (hi_rdata !== 32'hFFFFFFF9) begin n_bad++; $display("[TB] FAIL cancel_hi: got %h expected fffffff9", hi_rdata); end
    n_cmp++; if (lo_rdata !== 32'd1) begin n_bad++; $display("[TB] FAIL cancel_lo: got %h expected 00000001", lo_rdata); end
  endtask

  task automatic test_back_to_back;
    int busy_n, done_n, extra;
    @(negedge clk);
    hi_we = 1'b1; hilo_wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; hilo_wdata = 32'h55AA;
    #1;
    n_cmp++; if (hi_rdata !== 32'h1234) begin n_bad++; $display("[TB] FAIL mthi_hi: got %h expected 00001234", hi_rdata); end
    n_cmp++; if (lo_rdata !== 32'd1) begin n_bad++; $display("[TB] FAIL mthi_lo_kept: got %h expected 00000001", lo_rdata); end
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    n_cmp++; if (lo_rdata !== 32'h55AA) begin n_bad++; $display("[TB] FAIL mtlo_lo: got %h expected 000055aa", lo_rdata); end
    run_div(1'b0, 32'd9, 32'd4, busy_n, done_n);
    n_cmp++; if (busy_n !== 33 || done_n !== 1) begin n_bad++; $display("[TB] FAIL b2b_first: got busy %0d done %0d expected 33 1", busy_n, done_n); end
    run_div(1'b0, 32'd10, 32'd3, busy_n, done_n);
    n_cmp++; if (busy_n !== 33 || done_n !== 1) begin n_bad++; $display("[TB] FAIL b2b_second: got busy %0d done %0d expected 33 1", busy_n, done_n); end
    n_cmp++; if (hi_rdata !== 32'd1 || lo_rdata !== 32'd2) begin n_bad++; $display("[TB] FAIL b2b_mid_hilo: got %h/%h expected 00000001/00000002", hi_rdata, lo_rdata); end
    end_div(extra);
    n_cmp++; if (hi_rdata !== 32'd1 || lo_rdata !== 32'd3 || extra !== 0) begin n_bad++; $display("[TB] FAIL b2b_end_hilo: got %h/%h extra %0d expected 00000001/00000003 0", hi_rdata, lo_rdata, extra); end
  endtask

  // MTHI/MTLO is held high through the start, RUN and DONE cycles. It must have no effect.
  task automatic test_mthi_in_run;
    int busy_n, done_n, extra;
    hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = 32'hDEADBEEF;
    run_div(1'b0, 32'd10, 32'd3, busy_n, done_n);
    end_div(extra);
    n_cmp++; if (done_n + extra !== 1) begin n_bad++; $display("[TB] FAIL mthi_run_done: got %0d expected 1", done_n + extra); end
    n_cmp++; if (hi_rdata !== 32'd1) begin n_bad++; $display("[TB] FAIL mthi_run_hi: got %h expected 00000001", hi_rdata); end
    n_cmp++; if (lo_rdata !== 32'd3) begin n_bad++; $display("[TB] FAIL mthi_run_lo: got %h expected 00000003", lo_rdata); end
  endtask

  task automatic test_reset_mid_run;
    int busy_n, done_n, extra;
    @(negedge clk);
    div_signed = 1'b0; div_dividend = 32'd100; div_divisor = 32'd7; div_start = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_cmp++; if (exe_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rstrun_busy: got %b expected 0", exe_busy); end
    n_cmp++; if (div_done !== 1'b0) begin n_bad++; $display("[TB] FAIL rstrun_done: got %b expected 0", div_done); end
    n_cmp++; if (hi_rdata !== 32'h0 || lo_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL rstrun_hilo: got %h/%h expected 0/0", hi_rdata, lo_rdata); end
    @(negedge clk);
    div_start = 1'b0;
    resetn    = 1'b1;
    #1;
    n_cmp++; if (exe_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rstrun_idle_busy: got %b expected 0", exe_busy); end
    run_div(1'b0, 32'd100, 32'd7, busy_n, done_n);
    end_div(extra);
    n_cmp++; if (busy_n !== 33 || done_n + extra !== 1) begin n_bad++; $display("[TB] FAIL rstrun_redo_ctl: got busy %0d done %0d expected 33 1", busy_n, done_n + extra); end
    n_cmp++; if (hi_rdata !== 32'd2 || lo_rdata !== 32'd14) begin n_bad++; $display("[TB] FAIL rstrun_redo_hilo: got %h/%h expected 00000002/0000000e", hi_rdata, lo_rdata); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_divzero();
    test_cancel();
    test_back_to_back();
    test_mthi_in_run();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Time limit in case the DUT hangs somewhere the bounded loops do not cover.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
